// File: rtl/vga_scan_ctrl_pkg.sv
// Shared constants and helpers for the VGA raster-scan controller: default 640x480@60
// timing, counter/colour widths, sync-window decode and the test-pattern colour bars.
package vga_scan_ctrl_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 12;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // True when lo <= cnt < hi.
  function automatic logic in_window(logic [CNT_W-1:0] cnt, int unsigned lo, int unsigned hi);
    return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(hi));
  endfunction

  // Eight 80-pixel-wide bars across the 640-pixel active line.
  function automatic logic [RGB_W-1:0] bar_colour(logic [CNT_W-1:0] h);
    logic [RGB_W-1:0] c;
    if (h < CNT_W'(80))       c = 12'hFFF;
    else if (h < CNT_W'(160)) c = 12'hFF0;
    else if (h < CNT_W'(240)) c = 12'h0FF;
    else if (h < CNT_W'(320)) c = 12'h0F0;
    else if (h < CNT_W'(400)) c = 12'hF0F;
    else if (h < CNT_W'(480)) c = 12'hF00;
    else if (h < CNT_W'(560)) c = 12'h00F;
    else                      c = 12'h000;
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// Pixel-rate divider plus horizontal/vertical scan counters for the VGA controller.
module vga_sync_cnt
  import vga_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;

  assign pix_tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      // Explicit wrap keeps non-power-of-two dividers correct.
      div_q <= pix_tick ? '0 : div_q + 1'b1;
      if (pix_tick) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end
    end
  end

  assign h_cnt  = h_q;
  assign v_cnt  = v_q;
  assign active = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster-scan controller: image-memory address stage followed by an aligned colour/sync
// output stage. Define VGA_TEST_PATTERN_EN to add the test_pat colour-bar input.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] im_pixel_x,
  output logic [CNT_W-1:0] im_pixel_y,
  input  logic [RGB_W-1:0] im_rgb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_pat,
`endif
  output logic [RGB_W-1:0] vga_rgb,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic             pix_tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;

  vga_sync_cnt #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_sync_cnt (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .active   (active)
  );

  logic [CNT_W-1:0] x_q, y_q;
  logic [CNT_W-1:0] h_d_q, v_d_q;
  logic             act_d_q;
  logic [RGB_W-1:0] rgb_q;
  logic             hs_q, vs_q, fs_q;
  logic [RGB_W-1:0] pix_rgb;

  always_comb begin
    pix_rgb = im_rgb;
`ifdef VGA_TEST_PATTERN_EN
    if (test_pat) pix_rgb = bar_colour(h_d_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      h_d_q   <= '0;
      v_d_q   <= '0;
      act_d_q <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (pix_tick) begin
        // Address stage.
        x_q     <= active ? h_cnt : '0;
        y_q     <= active ? v_cnt : '0;
        h_d_q   <= h_cnt;
        v_d_q   <= v_cnt;
        act_d_q <= active;
        fs_q    <= (h_cnt == '0) && (v_cnt == '0);
        // Output stage uses the scan position that was addressed one tick earlier, so the
        // returned memory data, blanking and syncs all refer to the same pixel.
        rgb_q   <= act_d_q ? pix_rgb : '0;
        hs_q    <= ~in_window(h_d_q, H_SYNC_START, H_SYNC_END);
        vs_q    <= ~in_window(v_d_q, V_SYNC_START, V_SYNC_END);
      end
    end
  end

  assign im_pixel_x  = x_q;
  assign im_pixel_y  = y_q;
  assign vga_rgb     = rgb_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: a reference model built from pixel-tick arithmetic
// pushes per-clock expectations; a negedge monitor pops and compares every DUT output.
module tb_vga_scan_ctrl;

  localparam int unsigned CD = 4;
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VA = 2, VF = 1, VS = 1, VB = 1;
`else
  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 12, VF = 2, VS = 2, VB = 3;
`endif
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  im_pixel_x, im_pixel_y;
  logic [11:0] im_rgb = 12'h000;
  logic [11:0] m1 = 12'h000;
  logic        tp;
  logic [11:0] vga_rgb;
  logic        vga_hsync, vga_vsync, frame_start;
  logic [11:0] key;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .CLK_DIV  (CD),
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_pixel_x  (im_pixel_x),
    .im_pixel_y  (im_pixel_y),
    .im_rgb      (im_rgb),
`ifdef VGA_TEST_PATTERN_EN
    .test_pat    (tp),
`endif
    .vga_rgb     (vga_rgb),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .frame_start (frame_start)
  );

  function automatic logic [11:0] mem_f(int x, int y, logic [11:0] k);
    logic [9:0] xx, yy;
    xx = 10'(x);
    yy = 10'(y);
    return {xx[3:0], yy[3:0], xx[7:4]} ^ k;
  endfunction

  function automatic logic [11:0] bar_ref(int x);
    logic [11:0] tbl [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return tbl[x / 80];
  endfunction

  // Image memory with a 2-clock read latency.
  always @(posedge clk) begin
    m1     <= mem_f(int'(im_pixel_x), int'(im_pixel_y), key);
    im_rgb <= m1;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   ecnt, n, prev_h, prev_v, h, v;
  bit   have_prev;
  int   tests = 0;
  int   fails = 0;

  // Reference model: the n-th pixel tick after reset release visits scan position
  // (n mod HT, (n / HT) mod VT); outputs show the position visited one tick earlier.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        ecnt = 0;
        n = 0;
        have_prev = 0;
        cur = '{x: 10'd0, y: 10'd0, rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
      end else begin
        cur.fs = 1'b0;
        if (ecnt % CD == CD - 1) begin
          h = n % HT;
          v = (n / HT) % VT;
          if (have_prev) begin
            if (prev_h < HA && prev_v < VA)
              cur.rgb = tp ? bar_ref(prev_h) : mem_f(prev_h, prev_v, key);
            else
              cur.rgb = 12'h000;
            cur.hs = !(prev_h >= HA + HF && prev_h < HA + HF + HS);
            cur.vs = !(prev_v >= VA + VF && prev_v < VA + VF + VS);
          end
          cur.x  = (h < HA && v < VA) ? 10'(h) : 10'd0;
          cur.y  = (h < HA && v < VA) ? 10'(v) : 10'd0;
          cur.fs = (h == 0 && v == 0);
          prev_h = h;
          prev_v = v;
          have_prev = 1;
          n++;
        end
        ecnt++;
      end
      q.push_back(cur);
    end
  end

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("im_pixel_x", int'(im_pixel_x), int'(e.x));
        check("im_pixel_y", int'(im_pixel_y), int'(e.y));
        check("vga_rgb", int'(vga_rgb), int'(e.rgb));
        check("vga_hsync", int'(vga_hsync), int'(e.hs));
        check("vga_vsync", int'(vga_vsync), int'(e.vs));
        check("frame_start", int'(frame_start), int'(e.fs));
      end
    end
  end

  task automatic run(int cycles, bit toggle_tp);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (toggle_tp && i == cycles / 2) tp = ~tp;
    end
  endtask

  task automatic pulse_reset(int cycles);
    rst = 1'b0;
    key = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
    tp = 1'($urandom_range(0, 1));
`endif
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    tp  = 1'b0;
    key = 12'($urandom);
    repeat (10) @(negedge clk);
    rst = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    run(FRAME + int'($urandom_range(0, FRAME / 4)), 1'b1);
    pulse_reset(1);
    run(FRAME / 2 + int'($urandom_range(0, FRAME / 4)), 1'b1);
    pulse_reset(1);
    run(FRAME / 2, 1'b1);
`else
    run(2 * FRAME + int'($urandom_range(0, FRAME)), 1'b0);
    pulse_reset(1);
    run(FRAME / 2 + int'($urandom_range(0, FRAME)), 1'b0);
    pulse_reset(3);
    run(2 * FRAME, 1'b0);
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
